// File: rtl/axi_sd_filler_pkg.sv
// Shared types and helpers for the SD data-path burst DMA.
package axi_sd_filler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    BURST  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Smallest of three unsigned quantities; used to size each burst.
  function automatic int unsigned min3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/axi_sd_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a synchronous clear.
// Writes while full and reads while empty are dropped.
module axi_sd_fifo #(
  parameter int W = 32,
  parameter int A = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] dat_i,
  input  logic         pop_i,
  output logic [W-1:0] dat_o,
  output logic [A:0]   count_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2**A];
  logic [A-1:0] wptr_q, rptr_q;
  logic [A:0]   cnt_q;
  logic         do_push, do_pop;

  assign full_o  = (cnt_q == (A+1)'(2**A));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dat_o   = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= dat_i;
  end

  // Pointers and occupancy; a same-cycle push and pop leave the count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + A'(1);
      if (do_pop)  rptr_q <= rptr_q + A'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (A+1)'(1);
        2'b01:   cnt_q <= cnt_q - (A+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_sd_burst_filler.sv
// SD data-path DMA: moves an exact word count between the serial engine FIFOs
// and a burst bus master port, never crossing a BOUNDARY_BYTES boundary.
//
//   state  | meaning
//   IDLE   | waiting for en_rx_i / en_tx_i; latches address, length, direction
//   ARM    | sizes the next burst, waits for FIFO room/data, or finishes/aborts
//   BURST  | bus_stb_o high, one word per ack, ends on bus_last_i
//   FINISH | one-cycle done_o pulse, back to IDLE
module axi_sd_burst_filler
  import axi_sd_filler_pkg::*;
#(
  parameter int FIFO_ADDR_BITS = 6,
  parameter int ADDR_W         = 32,
  parameter int MAX_BURST      = 16,
  parameter int BOUNDARY_BYTES = 4096,
  parameter int LEN_W          = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clock_posedge,
  output logic [ADDR_W-3:0]       bus_adr_o,
  output logic [7:0]              bus_len_o,
  output logic [31:0]             bus_dat_o,
  input  logic [31:0]             bus_dat_i,
  output logic                    bus_we_o,
  output logic                    bus_stb_o,
  input  logic                    bus_ack_i,
  input  logic                    bus_last_i,
  input  logic                    en_rx_i,
  input  logic                    en_tx_i,
  input  logic [ADDR_W-3:0]       adr_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic [31:0]             dat_i,
  input  logic                    wr_i,
  output logic [31:0]             dat_o,
  input  logic                    rd_i,
  output logic [FIFO_ADDR_BITS:0] tx_free,
  output logic [FIFO_ADDR_BITS:0] rx_data,
  output logic                    rx_full_o,
  output logic                    rx_empty_o,
  output logic                    tx_empty_o,
  output logic                    tx_ready_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int DEPTH     = 2**FIFO_ADDR_BITS;
  localparam int HALF      = DEPTH / 2;
  localparam int BND_WORDS = BOUNDARY_BYTES / 4;
  localparam int BND_BITS  = $clog2(BND_WORDS);

  state_t            state_q;
  logic [ADDR_W-3:0] adr_q;
  logic [LEN_W-1:0]  words_left_q;
  logic              dir_rx_q;
  logic [7:0]        beats_q;
  logic [7:0]        beat_cnt_q;
  logic              done_q, err_q, tx_all_q, tx_clr_q;

  logic [FIFO_ADDR_BITS:0] rx_cnt, tx_cnt;
  logic        tx_full;
  logic [31:0] to_bnd_d, beats_d;
  logic [7:0]  beat_nxt;
  logic        en_hold, level_ok;
  logic        rx_pop, tx_push;

  assign to_bnd_d = 32'(BND_WORDS) - 32'(adr_q[BND_BITS-1:0]);
  assign beats_d  = min3(32'(MAX_BURST), 32'(words_left_q), to_bnd_d);
  assign beat_nxt = beat_cnt_q + 8'd1;
  assign en_hold  = dir_rx_q ? en_rx_i : en_tx_i;
  assign level_ok = dir_rx_q ? (32'(rx_cnt) >= beats_d) : (32'(tx_free) >= beats_d);

  assign rx_pop  = (state_q == BURST) & bus_ack_i &  dir_rx_q & ~rx_empty_o;
  assign tx_push = (state_q == BURST) & bus_ack_i & ~dir_rx_q & ~tx_full;

  assign bus_adr_o  = adr_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rx_data    = rx_cnt;
  assign tx_free    = (FIFO_ADDR_BITS+1)'(DEPTH) - tx_cnt;
  assign tx_ready_o = (tx_cnt >= (FIFO_ADDR_BITS+1)'(HALF)) | tx_all_q;

  axi_sd_fifo #(.W(32), .A(FIFO_ADDR_BITS)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (1'b0),
    .push_i  (wr_i & clock_posedge),
    .dat_i   (dat_i),
    .pop_i   (rx_pop),
    .dat_o   (bus_dat_o),
    .count_o (rx_cnt),
    .full_o  (rx_full_o),
    .empty_o (rx_empty_o)
  );

  axi_sd_fifo #(.W(32), .A(FIFO_ADDR_BITS)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (tx_clr_q),
    .push_i  (tx_push),
    .dat_i   (bus_dat_i),
    .pop_i   (rd_i & clock_posedge),
    .dat_o   (dat_o),
    .count_o (tx_cnt),
    .full_o  (tx_full),
    .empty_o (tx_empty_o)
  );

  // Transfer sequencer with address, length and beat counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      words_left_q <= '0;
      dir_rx_q     <= 1'b0;
      beats_q      <= '0;
      beat_cnt_q   <= '0;
      bus_stb_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_len_o    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tx_all_q     <= 1'b0;
      tx_clr_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      tx_clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en_rx_i | en_tx_i) begin
            adr_q        <= adr_i;
            words_left_q <= len_i;
            dir_rx_q     <= en_rx_i;
            err_q        <= 1'b0;
            tx_all_q     <= 1'b0;
            state_q      <= ARM;
          end
        end
        ARM: begin
          if (words_left_q == '0) begin
            done_q   <= 1'b1;
            tx_all_q <= ~dir_rx_q;
            state_q  <= FINISH;
          end else if (!en_hold) begin
            // Aborted TX data would be stale for the next transfer.
            tx_clr_q <= ~dir_rx_q;
            state_q  <= IDLE;
          end else if (level_ok) begin
            bus_stb_o  <= 1'b1;
            bus_we_o   <= dir_rx_q;
            bus_len_o  <= 8'(beats_d - 32'd1);
            beats_q    <= 8'(beats_d);
            beat_cnt_q <= '0;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (bus_ack_i) begin
            adr_q      <= adr_q + (ADDR_W-2)'(1);
            beat_cnt_q <= beat_nxt;
            if (words_left_q != '0) words_left_q <= words_left_q - LEN_W'(1);
            if (bus_last_i) begin
              bus_stb_o <= 1'b0;
              if (beat_nxt != beats_q) err_q <= 1'b1;
              state_q <= ARM;
            end else if (beat_nxt == beats_q) begin
              err_q <= 1'b1;
            end
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
